// File: rtl/input_conditioner.sv
// input_conditioner: debounces the enter button and captures the action switches into a ready/valid command.
// Define INPUT_CONDITIONER_DEBOUNCE_EN to enable the debounce counter; otherwise presses are accepted immediately.
module input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enter_sync,
    input  logic [0:5] acoes_sync,
    output logic       enter_pulse,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [0:5] cmd_acoes,
    output logic       cmd_overrun
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HELD = 2'd2;

    logic [1:0] r_state;
    logic       w_accept;
    logic       r_pulse;
    logic       r_valid;
    logic       r_ovr;
    logic [0:5] r_acoes;

`ifdef INPUT_CONDITIONER_DEBOUNCE_EN
    localparam logic [1:0] DEB_PRESS   = 2'd1;
    localparam logic [1:0] DEB_RELEASE = 2'd3;
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] r_cnt;
    logic          w_done;

    assign w_done   = r_cnt == CW'(DEBOUNCE_CYCLES - 1);
    assign w_accept = r_state == DEB_PRESS && enter_sync && w_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: if (enter_sync) begin
                    r_state <= DEB_PRESS;
                    r_cnt   <= '0;
                end
                DEB_PRESS: if (!enter_sync) r_state <= IDLE;
                    else if (w_done) r_state <= HELD;
                    else r_cnt <= r_cnt + 1'b1;
                HELD: if (!enter_sync) begin
                    r_state <= DEB_RELEASE;
                    r_cnt   <= '0;
                end
                default: if (enter_sync) r_state <= HELD;
                    else if (w_done) r_state <= IDLE;
                    else r_cnt <= r_cnt + 1'b1;
            endcase
        end
    end
`else
    // The parameter still gates acceptance so an illegal value of 0 never produces presses.
    assign w_accept = r_state == IDLE && enter_sync && (DEBOUNCE_CYCLES > 0);

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else if (r_state == IDLE && enter_sync) r_state <= HELD;
        else if (r_state == HELD && !enter_sync) r_state <= IDLE;
    end
`endif

    // A press while a command is pending and not being consumed is dropped and flagged.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pulse <= 1'b0;
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
            r_acoes <= '0;
        end else begin
            r_pulse <= w_accept;
            if (w_accept && (!r_valid || cmd_ready)) begin
                r_acoes <= acoes_sync;
                r_valid <= 1'b1;
            end else begin
                if (w_accept) r_ovr <= 1'b1;
                if (cmd_ready) r_valid <= 1'b0;
            end
        end
    end

    assign enter_pulse = r_pulse;
    assign cmd_valid   = r_valid;
    assign cmd_overrun = r_ovr;
    assign cmd_acoes   = r_acoes;
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: directed and random stimulus against a run-length model of the debounced button.
module tb_input_conditioner;
`ifdef INPUT_CONDITIONER_DEBOUNCE_EN
    localparam int D = 4;
`else
    localparam int D = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enter_sync = 1'b0;
    logic       cmd_ready = 1'b0;
    logic [0:5] acoes_sync = '0;
    logic [0:5] cmd_acoes;
    logic       enter_pulse;
    logic       cmd_valid;
    logic       cmd_overrun;

    int n_cmp = 0;
    int n_bad = 0;

    logic       m_pressed = 1'b0;
    int         m_run = 0;
    logic       m_pulse = 1'b0;
    logic       m_valid = 1'b0;
    logic       m_ovr = 1'b0;
    logic [0:5] m_acoes = '0;

    always #5 clk = ~clk;

    input_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
        .clk(clk),
        .reset(reset),
        .enter_sync(enter_sync),
        .acoes_sync(acoes_sync),
        .enter_pulse(enter_pulse),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_acoes(cmd_acoes),
        .cmd_overrun(cmd_overrun)
    );

    // Model: a press/release is accepted once D+1 consecutive samples disagree with the debounced level.
    task automatic step(input logic rst, input logic en, input logic rdy, input logic [0:5] a);
        logic acc;
        logic hs;
        reset = rst;
        enter_sync = en;
        cmd_ready = rdy;
        acoes_sync = a;
        acc = 1'b0;
        if (rst) begin
            m_pressed = 1'b0;
            m_run = 0;
            m_pulse = 1'b0;
            m_valid = 1'b0;
            m_ovr = 1'b0;
            m_acoes = '0;
        end else begin
            if (en != m_pressed) begin
                m_run++;
                if (m_run == D + 1) begin
                    m_pressed = en;
                    m_run = 0;
                    acc = en;
                end
            end else m_run = 0;
            hs = m_valid && rdy;
            if (acc && (!m_valid || hs)) begin
                m_acoes = a;
                m_valid = 1'b1;
            end else begin
                if (acc) m_ovr = 1'b1;
                if (hs) m_valid = 1'b0;
            end
            m_pulse = acc;
        end
        @(posedge clk);
        #1;
        n_cmp++;
        assert (enter_pulse === m_pulse) else begin
            n_bad++;
            $error("FAIL pulse got %b want %b", enter_pulse, m_pulse);
        end
        n_cmp++;
        assert (cmd_valid === m_valid) else begin
            n_bad++;
            $error("FAIL valid got %b want %b", cmd_valid, m_valid);
        end
        n_cmp++;
        assert (cmd_overrun === m_ovr) else begin
            n_bad++;
            $error("FAIL overrun got %b want %b", cmd_overrun, m_ovr);
        end
        n_cmp++;
        assert (cmd_acoes === m_acoes) else begin
            n_bad++;
            $error("FAIL acoes got %b want %b", cmd_acoes, m_acoes);
        end
    endtask

    task automatic hold(input int n, input logic en, input logic rdy, input logic [0:5] a);
        for (int i = 0; i < n; i++) step(1'b0, en, rdy, a);
    endtask

    initial begin
        @(posedge clk);
        #1;
        step(1'b1, 1'b0, 1'b0, 6'b000000);
        step(1'b1, 1'b0, 1'b0, 6'b000000);
        hold(10, 1'b1, 1'b0, 6'b101010);
        hold(10, 1'b0, 1'b0, 6'b000000);
        hold(3, 1'b0, 1'b1, 6'b000000);
        hold(3, 1'b1, 1'b0, 6'b110011);
        hold(10, 1'b0, 1'b0, 6'b110011);
        hold(10, 1'b1, 1'b1, 6'b001100);
        hold(2, 1'b0, 1'b1, 6'b001100);
        hold(1, 1'b1, 1'b1, 6'b001100);
        hold(10, 1'b0, 1'b1, 6'b001100);
        step(1'b1, 1'b0, 1'b0, 6'b000000);
        hold(10, 1'b1, 1'b0, 6'b101010);
        hold(10, 1'b0, 1'b0, 6'b101010);
        hold(10, 1'b1, 1'b0, 6'b010101);
        hold(10, 1'b0, 1'b0, 6'b010101);
        hold(3, 1'b0, 1'b1, 6'b000000);
        step(1'b1, 1'b0, 1'b0, 6'b000000);
        hold(10, 1'b1, 1'b0, 6'b000111);
        hold(10, 1'b0, 1'b0, 6'b000111);
        hold(D, 1'b1, 1'b0, 6'b111000);
        step(1'b0, 1'b1, 1'b1, 6'b111000);
        hold(5, 1'b1, 1'b0, 6'b111000);
        hold(10, 1'b0, 1'b0, 6'b111000);
        step(1'b1, 1'b0, 1'b0, 6'b000000);
        hold(3, 1'b1, 1'b0, 6'b011110);
        step(1'b1, 1'b1, 1'b0, 6'b011110);
        hold(10, 1'b1, 1'b0, 6'b011110);
        hold(10, 1'b0, 1'b1, 6'b011110);
        for (int k = 0; k < 400; k++) begin
            int len;
            logic en;
            len = int'($urandom_range(1, 8));
            en = 1'($urandom);
            for (int j = 0; j < len; j++)
                step(($urandom_range(0, 99) == 0), en, 1'($urandom), 6'($urandom));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
- REQ-001: Parameter DEBOUNCE_CYCLES, default 500000; the number of extra consecutive clk samples of stable enter_sync needed to accept a press or release. Legal range is 1 or more.
- REQ-002: clk, input, 1 bit; the single clock, rising-edge active.
- REQ-003: reset, input, 1 bit; synchronous, active-high reset, sampled on the rising edge of clk.
- REQ-004: enter_sync, input, 1 bit; the already-synchronized enter button (1 = pressed).
- REQ-005: acoes_sync [0:5], input, 6 x 1 bit; the already-synchronized action switches.
- REQ-006: enter_pulse, output, 1 bit; a one-cycle strobe for each accepted press.
- REQ-007: cmd_valid, output, 1 bit; a captured command is pending for the consumer.
- REQ-008: cmd_ready, input, 1 bit; the consumer accepts the command while cmd_valid is high.
- REQ-009: cmd_acoes [0:5], output, 6 x 1 bit; the action switches captured at press acceptance.
- REQ-010: cmd_overrun, output, 1 bit; sticky flag meaning a press was dropped because a command was still pending.

Function
- REQ-011: The FSM SHALL have four states: IDLE, DEB_PRESS, HELD and DEB_RELEASE. All outputs and the FSM state SHALL be registered.
- REQ-012: In IDLE, when enter_sync is 1, the FSM SHALL move to DEB_PRESS and clear the counter.
- REQ-013: In DEB_PRESS:
  - if enter_sync is 0, the FSM SHALL return to IDLE and no pulse SHALL be generated;
  - if enter_sync is 1 and counter equals DEBOUNCE_CYCLES-1, the FSM SHALL move to HELD and accept the press;
  - otherwise the counter SHALL increment.
- REQ-014: In HELD, when enter_sync is 0, the FSM SHALL move to DEB_RELEASE and clear the counter.
- REQ-015: In DEB_RELEASE:
  - if enter_sync is 1, the FSM SHALL return to HELD and no second pulse SHALL be generated;
  - if enter_sync is 0 and counter equals DEBOUNCE_CYCLES-1, the FSM SHALL move to IDLE;
  - otherwise the counter SHALL increment.
- REQ-016: The counter SHALL be $clog2(DEBOUNCE_CYCLES+1) bits wide and SHALL never wrap.
- REQ-017: Press latency: enter_pulse SHALL be high for exactly the one cycle after DEBOUNCE_CYCLES+1 consecutive samples of enter_sync=1 taken starting in IDLE.
- REQ-018: On press acceptance:
  - if cmd_valid is 0, or cmd_valid and cmd_ready are both 1, cmd_acoes SHALL load acoes_sync and cmd_valid SHALL be 1 the next cycle;
  - otherwise cmd_acoes SHALL be held and cmd_overrun SHALL be set.
- REQ-019: cmd_valid SHALL clear the cycle after cmd_valid and cmd_ready are both 1, unless REQ-018 reloads it in that same cycle.
- REQ-020: While cmd_valid is 1 and no handshake has occurred, cmd_acoes SHALL remain stable.
- REQ-021: cmd_overrun SHALL stay 1 until reset.
- REQ-022: enter_pulse SHALL be generated on press acceptance regardless of the cmd_valid and overrun outcome.

Reset
- REQ-023: When reset is 1 at a clock edge, the block SHALL set:
  - the FSM to IDLE and the counter to 0;
  - enter_pulse, cmd_valid and cmd_overrun to 0;
  - cmd_acoes to all 0.
- REQ-024: Reset SHALL take priority over every other event, including a press completing in the same cycle. A press aborted by reset SHALL produce no pulse.
- REQ-025: If enter_sync is held at 1 through the release of reset, it SHALL be debounced as a fresh press from IDLE.

Configuration
- REQ-026: Macro INPUT_CONDITIONER_DEBOUNCE_EN.
  - Defined: the block SHALL behave as in REQ-012..REQ-017.
  - Undefined: the counter SHALL be omitted and DEB_PRESS and DEB_RELEASE SHALL be bypassed. IDLE with enter_sync=1 SHALL go directly to HELD and accept the press, so the pulse appears one cycle after the first high sample. HELD with enter_sync=0 SHALL go directly to IDLE.
  - The handshake and overrun behaviour SHALL be identical in both builds.

Verification (DEBOUNCE_CYCLES=4, macro defined unless noted)
- REQ-027: enter_sync high for 10 cycles with acoes=101010 -> one enter_pulse, 5 cycles after the first high sample. cmd_valid=1 and cmd_acoes=101010 the same cycle.
- REQ-028: enter_sync high for 3 cycles, then low -> no enter_pulse and cmd_valid stays 0. Release bounce (low 2 cycles, high, then low 10 cycles) -> no second pulse.
- REQ-029: cmd_ready=0, press with 101010, then a full press with 010101 -> cmd_acoes=101010 and cmd_overrun=1. Then cmd_ready=1 -> cmd_valid=0 the next cycle, with cmd_overrun still 1.
- REQ-030: cmd_valid=1 with cmd_ready=1 in the same cycle as press acceptance with 111000 -> cmd_valid stays 1, cmd_acoes=111000 and cmd_overrun=0.
- REQ-031: reset asserted in the 3rd DEB_PRESS cycle while enter_sync stays high -> all outputs 0. The pulse appears 5 cycles after reset deasserts.
- REQ-032: Macro undefined, enter_sync high for 1 cycle -> enter_pulse one cycle later and cmd_valid=1.
